bist_pattern_gen: RTL and testbench
===================================

BIST_PATTERN_GEN -- requirements
Module: bist_pattern_gen

Interface
REQ-001 Parameter CHAIN_LEN, default 16: scan-chain length in flops; SHALL be at least 1.
REQ-002 Parameter NUM_PATTERNS, default 64: number of pattern/capture iterations per run; SHALL be at least 1.
REQ-003 Parameter SEED, default 16'hACE1: LFSR load value; SHALL be nonzero, and a zero value SHALL be replaced by 16'h0001.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-006 Port start, input, 1: run request, sampled in IDLE and DONE.
REQ-007 Port abort, input, 1: synchronous abort; forces IDLE on the next edge.
REQ-008 Port scan_en, output, 1: CUT scan enable, 1 during shift.
REQ-009 Port scan_in, output, 1: serial pattern bit to the CUT scan chain.
REQ-010 Port pi_vec, output, 5: CUT primary inputs {s, dv, l_in, test_in[1:0]}.
REQ-011 Port capture, output, 1: one-cycle pulse marking the CUT functional capture cycle.
REQ-012 Port pattern_cnt, output, 16: number of captures completed in the current run.
REQ-013 Port busy, output, 1: 1 in SHIFT, CAPTURE and UNLOAD.
REQ-014 Port done, output, 1: 1 in DONE only.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, CAPTURE, UNLOAD and DONE.
REQ-016 IDLE with start=1: load the LFSR with SEED, clear shift_cnt and pattern_cnt, go to SHIFT.
REQ-017 SHIFT: scan_en=1, scan_in=lfsr[0]; the LFSR advances once and shift_cnt increments each cycle; after exactly CHAIN_LEN SHIFT cycles, go to CAPTURE.
REQ-018 LFSR: 16-bit Fibonacci, right shift, new MSB = l[0]^l[2]^l[3]^l[5] (x^16+x^14+x^13+x^11+1); it holds in every state except SHIFT.
REQ-019 Entry to CAPTURE: register pi_vec <= lfsr[4:0]. pi_vec SHALL stay stable until the next CAPTURE entry.
REQ-020 CAPTURE lasts exactly one cycle, with scan_en=0, scan_in=0 and capture=1.
REQ-021 On leaving CAPTURE, pattern_cnt increments. If the new value equals NUM_PATTERNS, go to UNLOAD; otherwise clear shift_cnt and go to SHIFT.
REQ-022 UNLOAD: scan_en=1 and scan_in=0 for CHAIN_LEN cycles to flush the last response, LFSR held, then go to DONE.
REQ-023 DONE: done=1 and outputs hold. start=1 restarts exactly as from IDLE (SEED reloaded); otherwise remain in DONE.
REQ-024 Run length from the start-sampling edge to done=1 SHALL be NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles.
REQ-025 abort=1 in any state SHALL go to IDLE next cycle, with scan_en=0, capture=0 and pattern_cnt held; abort takes priority over start.
REQ-026 In IDLE: scan_en=0, scan_in=0, capture=0, busy=0, done=0; start is ignored while busy.
REQ-027 shift_cnt width SHALL be clog2(CHAIN_LEN+1); pattern_cnt saturates at 16'hFFFF and never wraps.

Reset
REQ-028 While reset=0: state=IDLE, LFSR=SEED, counters=0, pi_vec=5'b00000, and all 1-bit outputs 0, applied immediately without a clock edge.
REQ-029 Reset released mid-run SHALL leave the block in IDLE, requiring a new start.

Structure
REQ-030 A shared package bist_pkg SHALL hold the FSM state enum, the LFSR polynomial tap constant, the default SEED and the LFSR width.
REQ-031 The LFSR SHALL be a separate sub-module bist_lfsr (ports: clock, reset, load, advance, seed, q).
REQ-032 scan_en, scan_in and capture SHALL be decoded from registered state only, with no combinational path from start or abort.

Verification
REQ-033 CHAIN_LEN=4, NUM_PATTERNS=3, start pulse -> scan_in sequence 1,0,0,0 in the first SHIFT; then pi_vec=5'b01110 (LFSR 16'h2ACE) with capture=1.
REQ-034 Same configuration -> done rises exactly 20 cycles after the start edge, and pattern_cnt=3.
REQ-035 abort asserted on the 2nd CAPTURE cycle -> IDLE next cycle, scan_en=0, pattern_cnt=2, done=0.
REQ-036 reset=0 mid-SHIFT -> all outputs 0 immediately; after release the block stays IDLE until start, and the rerun reproduces the REQ-033 sequence.
REQ-037 start held high throughout a run -> no restart while busy; at DONE an immediate restart reloads SEED and yields an identical scan_in stream.
REQ-038 Connected to the cut scan netlist with the default configuration -> 64 captures, scan_en toggles correctly, and no X on scan_out after the first UNLOAD.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern generator: FSM states, LFSR
// geometry and polynomial taps, default seed and output widths.
package bist_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned PI_W   = 5;
  localparam int unsigned PCNT_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form:
  // new MSB = q[0] ^ q[2] ^ q[3] ^ q[5]
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/bist_pattern_gen_if.sv
// Bundle between the pattern generator and its controller / CUT.
//   start, abort  : run control into the generator
//   scan_en       : CUT scan enable
//   scan_in       : serial pattern bit to the scan chain
//   pi_vec        : CUT primary inputs {s, dv, l_in, test_in[1:0]}
//   capture       : one-cycle functional capture pulse
//   pattern_cnt   : captures completed in the current run
//   busy, done    : run status
// master = generator side, slave = controller / CUT side.
interface bist_pattern_gen_if;
  import bist_pkg::*;

  logic              start;
  logic              abort;
  logic              scan_en;
  logic              scan_in;
  logic [PI_W-1:0]   pi_vec;
  logic              capture;
  logic [PCNT_W-1:0] pattern_cnt;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort,
    output scan_en, scan_in, pi_vec, capture, pattern_cnt, busy, done
  );

  modport slave (
    output start, abort,
    input  scan_en, scan_in, pi_vec, capture, pattern_cnt, busy, done
  );

endinterface

// File: rtl/bist_lfsr.sv
// 16-bit right-shifting Fibonacci LFSR used as the BIST pattern source.
//   clock, reset : clock and async active-low reset (resets to SEED)
//   load         : load the (zero-protected) seed input
//   advance      : shift one step; otherwise the register holds
//   seed         : load value
//   q            : current LFSR contents
module bist_lfsr
  import bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  // load wins over advance so a restart always begins from the seed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= seed_fix(SEED);
    end else if (load) begin
      q <= seed_fix(seed);
    end else if (advance) begin
      q <= {fb, q[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/bist_pattern_gen.sv
// Scan-based BIST pattern generator: shifts LFSR patterns into a CUT scan
// chain, applies LFSR-derived primary inputs, pulses capture, repeats
// NUM_PATTERNS times, then flushes the chain and reports done.
//   clock, reset : clock and async active-low reset
//   bus          : bist_pattern_gen_if.master (control in, scan/status out)
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int unsigned       CHAIN_LEN    = 16,
  parameter int unsigned       NUM_PATTERNS = 64,
  parameter logic [LFSR_W-1:0] SEED         = DEFAULT_SEED
) (
  input  logic                clock,
  input  logic                reset,
  bist_pattern_gen_if.master  bus
);

  localparam int unsigned       SC_W      = $clog2(CHAIN_LEN + 1);
  localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(CHAIN_LEN - 1);
  localparam logic [LFSR_W-1:0] SEED_EFF  = seed_fix(SEED);
  localparam logic [PCNT_W-1:0] PC_TARGET = PCNT_W'(NUM_PATTERNS);

  state_t              state, state_nx;
  logic [SC_W-1:0]     shift_cnt;
  logic [PCNT_W-1:0]   pattern_cnt_q;
  logic [PCNT_W-1:0]   pc_plus;
  logic [PI_W-1:0]     pi_q;
  logic [LFSR_W-1:0]   lfsr_q;

  logic lfsr_load, lfsr_adv;
  logic sc_clr, sc_inc;
  logic pc_clr, pc_inc;
  logic pi_load;

  // saturating increment of the capture counter
  assign pc_plus = (pattern_cnt_q == '1) ? pattern_cnt_q
                                         : pattern_cnt_q + PCNT_W'(1);

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state and datapath controls
  always_comb begin
    state_nx  = state;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    sc_clr    = 1'b0;
    sc_inc    = 1'b0;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pi_load   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nx  = ST_SHIFT;
          lfsr_load = 1'b1;
          sc_clr    = 1'b1;
          pc_clr    = 1'b1;
        end
      end
      ST_SHIFT: begin
        lfsr_adv = 1'b1;
        if (shift_cnt == SC_LAST) begin
          state_nx = ST_CAPTURE;
          pi_load  = 1'b1;
          sc_clr   = 1'b1;
        end else begin
          sc_inc = 1'b1;
        end
      end
      ST_CAPTURE: begin
        pc_inc = 1'b1;
        sc_clr = 1'b1;
        state_nx = (pc_plus == PC_TARGET) ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        if (shift_cnt == SC_LAST) begin
          state_nx = ST_DONE;
        end else begin
          sc_inc = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // The capture pulse has already reached the CUT when abort lands in
    // CAPTURE, so that capture still counts; everything else freezes.
    if (bus.abort) begin
      state_nx  = ST_IDLE;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      sc_inc    = 1'b0;
      pc_clr    = 1'b0;
      pi_load   = 1'b0;
    end
  end

  // shift counter, capture counter and primary-input register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_cnt     <= '0;
      pattern_cnt_q <= '0;
      pi_q          <= '0;
    end else begin
      if (sc_clr) begin
        shift_cnt <= '0;
      end else if (sc_inc) begin
        shift_cnt <= shift_cnt + SC_W'(1);
      end
      if (pc_clr) begin
        pattern_cnt_q <= '0;
      end else if (pc_inc) begin
        pattern_cnt_q <= pc_plus;
      end
      // LFSR advances on this same edge, so q[5:1] is the post-shift q[4:0]
      if (pi_load) begin
        pi_q <= lfsr_q[PI_W:1];
      end
    end
  end

  bist_lfsr #(
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED_EFF),
    .q       (lfsr_q)
  );

  // scan controls decoded from the state register only
  assign bus.scan_en     = (state == ST_SHIFT) || (state == ST_UNLOAD);
  assign bus.scan_in     = (state == ST_SHIFT) && lfsr_q[0];
  assign bus.capture     = (state == ST_CAPTURE);
  assign bus.busy        = (state == ST_SHIFT) || (state == ST_CAPTURE) ||
                           (state == ST_UNLOAD);
  assign bus.done        = (state == ST_DONE);
  assign bus.pi_vec      = pi_q;
  assign bus.pattern_cnt = pattern_cnt_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Scoreboard bench for bist_pattern_gen (CHAIN_LEN=4, NUM_PATTERNS=3) plus
// a default-configuration instance for the full-length run.
module tb_bist_pattern_gen;
  import bist_pkg::*;

  localparam int unsigned L  = 4;
  localparam int unsigned N  = 3;
  localparam int          RUN_LEN  = N * (L + 1) + L + 1;      // 20
  localparam int          DRUN_LEN = 64 * (16 + 1) + 16 + 1;   // 1105

  typedef struct packed {
    logic              scan_en;
    logic              scan_in;
    logic              capture;
    logic [PI_W-1:0]   pi;
    logic [PCNT_W-1:0] pcnt;
    logic              chk_pi;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t e;
  logic ok;

  always #5 clock = ~clock;

  bist_pattern_gen_if u_if ();
  bist_pattern_gen_if u_if_d ();

  bist_pattern_gen #(
    .CHAIN_LEN    (L),
    .NUM_PATTERNS (N),
    .SEED         (16'hACE1)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.master)
  );

  bist_pattern_gen u_dut_d (
    .clock (clock),
    .reset (reset),
    .bus   (u_if_d.master)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Expected per-busy-cycle stream of a run starting from SEED. The first
  // pattern uses hand-derived values: scan_in 1,0,0,0 then pi 01110 with
  // the LFSR at 16'h2ACE.
  task automatic push_run(input int npat, input bit unload);
    logic [15:0] v;
    logic [3:0]  hand_bits;
    exp_t        x;
    hand_bits = 4'b0001;
    v = 16'hACE1;
    for (int p = 0; p < npat; p++) begin
      for (int i = 0; i < int'(L); i++) begin
        x = '{scan_en: 1'b1, scan_in: (p == 0) ? hand_bits[i] : v[0],
              capture: 1'b0, pi: '0, pcnt: 16'(p), chk_pi: 1'b0};
        sb.push_back(x);
        v = lfsr_step(v);
      end
      if (p == 0) v = 16'h2ACE;
      x = '{scan_en: 1'b0, scan_in: 1'b0, capture: 1'b1,
            pi: (p == 0) ? 5'b01110 : v[4:0], pcnt: 16'(p), chk_pi: 1'b1};
      sb.push_back(x);
    end
    if (unload) begin
      for (int i = 0; i < int'(L); i++) begin
        x = '{scan_en: 1'b1, scan_in: 1'b0, capture: 1'b0, pi: '0,
              pcnt: 16'(N), chk_pi: 1'b0};
        sb.push_back(x);
      end
    end
  endtask

  // start pulse, then count negedges until done (start edge = cycle 1)
  task automatic run_timed(output int k);
    @(negedge clock) u_if.start = 1'b1;
    @(negedge clock) u_if.start = 1'b0;
    k = 1;
    while (!u_if.done && k < 200) begin
      @(negedge clock);
      k++;
    end
  endtask

  // monitor: every busy cycle consumes one expected entry
  always @(negedge clock) begin
    if (reset && u_if.busy) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty: busy cycle with no expected entry (scan_en=%0b capture=%0b)",
                 u_if.scan_en, u_if.capture);
      end else begin
        e  = sb.pop_front();
        ok = (u_if.scan_en == e.scan_en) && (u_if.scan_in == e.scan_in) &&
             (u_if.capture == e.capture) && (u_if.pattern_cnt == e.pcnt) &&
             (!e.chk_pi || (u_if.pi_vec == e.pi));
        if (!ok) begin
          miscompares++;
          $display("FAIL stream: got en=%0b in=%0b cap=%0b pi=%05b cnt=%0d expected en=%0b in=%0b cap=%0b pi=%05b cnt=%0d",
                   u_if.scan_en, u_if.scan_in, u_if.capture, u_if.pi_vec,
                   u_if.pattern_cnt, e.scan_en, e.scan_in, e.capture, e.pi,
                   e.pcnt);
        end
      end
    end
  end

  initial begin
    int k, k1, w, caps, rises;
    logic prev_en;

    reset = 1'b0;
    u_if.start = 1'b0;  u_if.abort = 1'b0;
    u_if_d.start = 1'b0; u_if_d.abort = 1'b0;

    // reset values
    @(negedge clock);
    check("reset_outputs",
          {u_if.scan_en, u_if.scan_in, u_if.capture, u_if.busy, u_if.done,
           u_if.pi_vec, u_if.pattern_cnt}, '0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_no_start", {u_if.busy, u_if.done, u_if.scan_en}, '0);

    // abort beats start in IDLE
    u_if.start = 1'b1; u_if.abort = 1'b1;
    @(negedge clock);
    u_if.start = 1'b0; u_if.abort = 1'b0;
    check("abort_priority", {u_if.busy, u_if.done}, '0);

    // full run: stream, run length, final count
    push_run(N, 1'b1);
    run_timed(k);
    check("run_len", 32'(k), 32'(RUN_LEN));
    check("done_cnt", {u_if.done, u_if.pattern_cnt}, {1'b1, 16'd3});
    check("sb_drained_run", 32'(sb.size()), 0);
    repeat (2) @(negedge clock);
    check("done_hold", {u_if.done, u_if.busy, u_if.pattern_cnt}, {2'b10, 16'd3});

    // abort in the second CAPTURE cycle
    push_run(2, 1'b0);
    @(negedge clock) u_if.start = 1'b1;
    @(negedge clock) u_if.start = 1'b0;
    w = 0;
    while (!(u_if.capture && u_if.pattern_cnt == 16'd1) && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("abort_reach", 32'(w < 100), 1);
    u_if.abort = 1'b1;
    @(negedge clock) u_if.abort = 1'b0;
    check("abort_idle", {u_if.busy, u_if.done, u_if.scan_en, u_if.capture,
                         u_if.pattern_cnt}, {4'b0000, 16'd2});
    check("sb_drained_abort", 32'(sb.size()), 0);
    repeat (2) @(negedge clock);
    check("abort_stays_idle", {u_if.busy, u_if.done}, '0);

    // reset mid-SHIFT
    push_run(N, 1'b1);
    @(negedge clock) u_if.start = 1'b1;
    @(negedge clock) u_if.start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("reset_mid_shift",
             {u_if.scan_en, u_if.scan_in, u_if.capture, u_if.busy, u_if.done,
              u_if.pi_vec, u_if.pattern_cnt}, '0);
    sb.delete();
    @(negedge clock) reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_idle", {u_if.busy, u_if.done, u_if.scan_en}, '0);
    push_run(N, 1'b1);
    run_timed(k);
    check("rerun_len", 32'(k), 32'(RUN_LEN));
    check("sb_drained_rerun", 32'(sb.size()), 0);

    // start held high: no restart while busy, immediate restart at DONE
    push_run(N, 1'b1);
    push_run(N, 1'b1);
    @(negedge clock) u_if.start = 1'b1;
    @(negedge clock);
    k = 1;
    while (!u_if.done && k < 200) begin
      @(negedge clock);
      k++;
    end
    k1 = k;
    check("held_first_done", 32'(k1), 32'(RUN_LEN));
    @(negedge clock);
    k++;
    check("held_restart", {u_if.done, u_if.busy}, 2'b01);
    while (!u_if.done && k < 200) begin
      @(negedge clock);
      k++;
    end
    u_if.start = 1'b0;
    check("held_second_done", 32'(k), 32'(2 * RUN_LEN));
    check("sb_drained_held", 32'(sb.size()), 0);

    // default configuration: 64 captures, 65 scan_en bursts
    @(negedge clock) u_if_d.start = 1'b1;
    @(negedge clock) u_if_d.start = 1'b0;
    k = 1; caps = 0; rises = 0; prev_en = 1'b0;
    while (!u_if_d.done && k < 2000) begin
      if (u_if_d.capture) caps++;
      if (u_if_d.scan_en && !prev_en) rises++;
      prev_en = u_if_d.scan_en;
      @(negedge clock);
      k++;
    end
    check("dflt_run_len", 32'(k), 32'(DRUN_LEN));
    check("dflt_captures", 32'(caps), 64);
    check("dflt_scan_bursts", 32'(rises), 65);
    check("dflt_cnt", 32'(u_if_d.pattern_cnt), 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
